// File: rtl/cmprs_afi_mux_ptr_if.sv
// Burst-issue, write-response and pointer read-port signals between the AFI mux
// and its chunk pointer file.
interface cmprs_afi_mux_ptr_if #(
  parameter int unsigned W = 26
);
  logic         wr_start;
  logic [1:0]   wr_chn;
  logic [1:0]   wr_len;
  logic         wr_eof;
  logic [W-1:0] wr_ptr;
  logic         fifo_full;
  logic         bresp_valid;
  logic [3:0]   chunk_ptr_ra;
  logic [W-1:0] chunk_ptr_rd;

  modport master (
    output wr_start, wr_chn, wr_len, wr_eof, bresp_valid, chunk_ptr_ra,
    input  wr_ptr, fifo_full, chunk_ptr_rd
  );

  modport slave (
    input  wr_start, wr_chn, wr_len, wr_eof, bresp_valid, chunk_ptr_ra,
    output wr_ptr, fifo_full, chunk_ptr_rd
  );
endinterface

// File: rtl/cmprs_afi_mux_ptr.sv
// Per-channel chunk pointer file for the compressor AFI mux: write-side pointers advance
// on burst issue, response-side pointers advance on write responses via an in-flight FIFO.
module cmprs_afi_mux_ptr #(
  parameter int unsigned CMPRS_AFIMUX_WIDTH  = 26,
  parameter int unsigned CMPRS_AFIMUX_FIFO_A = 4
) (
  input  logic                            hclk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [4*CMPRS_AFIMUX_WIDTH-1:0] buf_len,
  input  logic [3:0]                      ptr_reset,
  cmprs_afi_mux_ptr_if.slave              bus,
  output logic                            err_ovf,
  output logic                            err_unf
);
  localparam int unsigned W     = CMPRS_AFIMUX_WIDTH;
  localparam int unsigned AW    = CMPRS_AFIMUX_FIFO_A;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NPTR  = 16;

  typedef struct packed {
    logic [1:0] chn;
    logic [1:0] len;
    logic       eof;
  } burst_t;

  // Pointer storage indexed {eof, wresp, chn[1:0]}, same layout as the read address.
  logic [W-1:0]  ptr_q [NPTR];
  logic [W-1:0]  ptr_d [NPTR];
  burst_t        fifo_q [DEPTH];
  logic [AW-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          push, pop;
  burst_t        head, wr_ent;
  logic [W-1:0]  adv_w, adv_r;

  function automatic logic [W-1:0] advance(input logic [W-1:0] ptr, input logic [1:0] len,
                                           input logic [W-1:0] blen);
    logic [W:0] sum;
    sum = {1'b0, ptr} + (W+1)'(len) + (W+1)'(1);
    if (sum >= {1'b0, blen}) sum = sum - {1'b0, blen};
    return W'(sum);
  endfunction

  assign head       = fifo_q[ra_q];
  assign wr_ent.chn = bus.wr_chn;
  assign wr_ent.len = bus.wr_len;
  assign wr_ent.eof = bus.wr_eof;

  // A pop in the same cycle frees the slot a full FIFO would otherwise lack; no bypass to an empty one.
  assign pop  = en && bus.bresp_valid && (cnt_q != '0);
  assign push = en && bus.wr_start && (!full_q || pop);

  assign adv_w = advance(ptr_q[{2'b00, bus.wr_chn}], bus.wr_len, buf_len[bus.wr_chn*W +: W]);
  assign adv_r = advance(ptr_q[{2'b01, head.chn}], head.len, buf_len[head.chn*W +: W]);

  always_comb begin
    ptr_d  = ptr_q;
    wa_d   = wa_q;
    ra_d   = ra_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (!en) begin
      wa_d   = '0;
      ra_d   = '0;
      cnt_d  = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (push) wa_d = wa_q + AW'(1);
      if (pop)  ra_d = ra_q + AW'(1);
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      full_d = (cnt_d == (AW+1)'(DEPTH));
      ovf_d  = ovf_q | (bus.wr_start & ~push);
      unf_d  = unf_q | (bus.bresp_valid & ~pop);
    end
    if (push) begin
      ptr_d[{2'b00, bus.wr_chn}] = adv_w;
      if (bus.wr_eof) ptr_d[{2'b10, bus.wr_chn}] = adv_w;
    end
    if (pop) begin
      ptr_d[{2'b01, head.chn}] = adv_r;
      if (head.eof) ptr_d[{2'b11, head.chn}] = adv_r;
    end
    // Channel reset wins over any same-cycle advance of that channel.
    for (int i = 0; i < NPTR; i++) begin
      if (ptr_reset[2'(i)]) ptr_d[i] = '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (rst) begin
      for (int i = 0; i < NPTR; i++) ptr_q[i] <= '0;
      wa_q   <= '0;
      ra_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wa_q   <= wa_d;
      ra_q   <= ra_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Entry storage needs no reset: only slots below the count are ever read.
  always_ff @(posedge hclk) begin
    if (push) fifo_q[wa_q] <= wr_ent;
  end

  assign bus.wr_ptr       = ptr_q[{2'b00, bus.wr_chn}];
  assign bus.chunk_ptr_rd = ptr_q[bus.chunk_ptr_ra];
  assign bus.fifo_full    = full_q;
  assign err_ovf          = ovf_q;
  assign err_unf          = unf_q;
endmodule

// File: tb/tb_cmprs_afi_mux_ptr.sv
// Scoreboard bench for cmprs_afi_mux_ptr: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cmprs_afi_mux_ptr;
  localparam int unsigned W = 26;
  localparam int K_RD = 0, K_WP = 1, K_FULL = 2, K_OVF = 3, K_UNF = 4;

  logic           hclk = 1'b0;
  logic           rst, en;
  logic [4*W-1:0] buf_len;
  logic [3:0]     ptr_reset;
  logic           err_ovf, err_unf;

  cmprs_afi_mux_ptr_if #(.W(W)) bus ();

  cmprs_afi_mux_ptr #(.CMPRS_AFIMUX_WIDTH(W), .CMPRS_AFIMUX_FIFO_A(4)) dut (
    .hclk(hclk), .rst(rst), .en(en), .buf_len(buf_len), .ptr_reset(ptr_reset),
    .bus(bus), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 hclk = ~hclk;

  int           kind_q[$];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           passed = 0;
  int           total  = 0;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input logic [1:0] chn, input logic [1:0] len, input logic eof,
                       input logic with_bresp);
    bus.wr_start    = 1'b1;
    bus.wr_chn      = chn;
    bus.wr_len      = len;
    bus.wr_eof      = eof;
    bus.bresp_valid = with_bresp;
    tick();
    bus.wr_start    = 1'b0;
    bus.wr_eof      = 1'b0;
    bus.bresp_valid = 1'b0;
  endtask

  task automatic bresp();
    bus.bresp_valid = 1'b1;
    tick();
    bus.bresp_valid = 1'b0;
  endtask

  task automatic expect_val(input int kind, input logic [3:0] sel, input logic [W-1:0] exp,
                            input string name);
    if (kind == K_RD) bus.chunk_ptr_ra = sel;
    if (kind == K_WP) bus.wr_chn = sel[1:0];
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
  endtask

  // Monitor: compares every pending expectation against the outputs settled this cycle.
  initial begin
    int           k;
    logic [W-1:0] e, act;
    string        n;
    forever begin
      @(negedge hclk);
      while (kind_q.size() > 0) begin
        k = kind_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_RD:    act = bus.chunk_ptr_rd;
          K_WP:    act = bus.wr_ptr;
          K_FULL:  act = W'(bus.fifo_full);
          K_OVF:   act = W'(err_ovf);
          default: act = W'(err_unf);
        endcase
        total++;
        if (act == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; ptr_reset = 4'h0;
    buf_len = {W'(40), W'(20), W'(10), W'(100)};
    bus.wr_start = 1'b0; bus.wr_chn = 2'd0; bus.wr_len = 2'd0; bus.wr_eof = 1'b0;
    bus.bresp_valid = 1'b0; bus.chunk_ptr_ra = 4'h0;
    tick(); tick();
    rst = 1'b0;

    expect_val(K_RD,   4'h0, 0, "reset_rd0");
    expect_val(K_RD,   4'hF, 0, "reset_rdF");
    expect_val(K_FULL, 4'h0, 0, "reset_full");
    expect_val(K_OVF,  4'h0, 0, "reset_ovf");
    expect_val(K_UNF,  4'h0, 0, "reset_unf");

    // Three 4-chunk bursts on chn0, then their responses
    for (int i = 0; i < 3; i++) issue(2'd0, 2'd3, 1'b0, 1'b0);
    expect_val(K_RD, 4'h0, 12, "t1_wr_chunk0");
    expect_val(K_RD, 4'h4, 0,  "t1_resp_before");
    expect_val(K_WP, 4'h0, 12, "t1_wr_ptr0");
    for (int i = 0; i < 3; i++) bresp();
    expect_val(K_RD, 4'h4, 12, "t1_resp_after");
    expect_val(K_RD, 4'h8, 0,  "t1_eof_untouched");

    // chn1 wraps at buf_len 10: 4,8 -> 2 -> 6 -> exactly 10 -> 0
    issue(2'd1, 2'd3, 1'b0, 1'b0);
    issue(2'd1, 2'd3, 1'b0, 1'b0);
    expect_val(K_RD, 4'h1, 8, "t2_at8");
    issue(2'd1, 2'd3, 1'b0, 1'b0);
    expect_val(K_RD, 4'h1, 2, "t2_wrap");
    issue(2'd1, 2'd3, 1'b0, 1'b0);
    expect_val(K_RD, 4'h1, 6, "t2_at6");
    issue(2'd1, 2'd3, 1'b0, 1'b0);
    expect_val(K_RD, 4'h1, 0, "t2_exact_wrap");
    for (int i = 0; i < 3; i++) bresp();
    expect_val(K_RD, 4'h5, 2, "t2_resp_wrap");
    bresp(); bresp();
    expect_val(K_RD, 4'h5, 0, "t2_resp_exact");

    // chn2 eof burst: write eof pointer immediately, response eof pointer after its bresp
    issue(2'd2, 2'd1, 1'b0, 1'b0);
    issue(2'd2, 2'd3, 1'b0, 1'b0);
    issue(2'd2, 2'd1, 1'b1, 1'b0);
    expect_val(K_RD, 4'hA, 8, "t3_wr_eof");
    expect_val(K_RD, 4'h2, 8, "t3_wr_chunk");
    expect_val(K_RD, 4'hE, 0, "t3_resp_eof_before");
    bresp(); bresp();
    expect_val(K_RD, 4'hE, 0, "t3_resp_eof_mid");
    bresp();
    expect_val(K_RD, 4'hE, 8, "t3_resp_eof_after");
    expect_val(K_RD, 4'h6, 8, "t3_resp_chunk");

    // Fill the 16-entry FIFO from chn3, then overflow
    for (int i = 0; i < 15; i++) issue(2'd3, 2'd0, 1'b0, 1'b0);
    expect_val(K_FULL, 4'h0, 0, "t4_full_at15");
    issue(2'd3, 2'd0, 1'b0, 1'b0);
    expect_val(K_FULL, 4'h0, 1,  "t4_full_at16");
    expect_val(K_OVF,  4'h0, 0,  "t4_ovf_before");
    expect_val(K_WP,   4'h3, 16, "t4_wr_ptr3");
    issue(2'd3, 2'd0, 1'b0, 1'b0);
    expect_val(K_OVF,  4'h0, 1,  "t4_ovf_set");
    expect_val(K_RD,   4'h3, 16, "t4_dropped");
    issue(2'd3, 2'd0, 1'b0, 1'b1);
    expect_val(K_RD,   4'h3, 17, "t4_push_pop_wr");
    expect_val(K_RD,   4'h7, 1,  "t4_push_pop_resp");
    expect_val(K_FULL, 4'h0, 1,  "t4_still_full");
    issue(2'd3, 2'd0, 1'b0, 1'b0);
    expect_val(K_RD,   4'h3, 17, "t4_count_kept");

    // en low flushes and clears errors; bresp on empty sets underflow
    en = 1'b0; tick(); en = 1'b1;
    expect_val(K_FULL, 4'h0, 0, "t5_full_flushed");
    expect_val(K_OVF,  4'h0, 0, "t5_ovf_cleared");
    bresp();
    expect_val(K_UNF, 4'h0, 1, "t5_unf_set");
    expect_val(K_RD,  4'h7, 1, "t5_unf_no_change");
    en = 1'b0;
    issue(2'd0, 2'd3, 1'b0, 1'b0);
    en = 1'b1;
    expect_val(K_UNF,  4'h0, 0,  "t5_unf_cleared");
    expect_val(K_RD,   4'h0, 12, "t5_en_ignores_wr");
    expect_val(K_FULL, 4'h0, 0,  "t5_full_low");

    // ptr_reset beats a same-cycle advance and leaves other channels alone
    issue(2'd3, 2'd0, 1'b1, 1'b0);
    expect_val(K_RD, 4'hB, 18, "t6_eof3_pre");
    ptr_reset = 4'b1000;
    issue(2'd3, 2'd1, 1'b1, 1'b0);
    ptr_reset = 4'b0000;
    expect_val(K_RD, 4'h3, 0,  "t6_rst_chunk3");
    expect_val(K_RD, 4'h7, 0,  "t6_rst_resp3");
    expect_val(K_RD, 4'hB, 0,  "t6_rst_eof3");
    expect_val(K_RD, 4'hF, 0,  "t6_rst_respeof3");
    expect_val(K_RD, 4'h0, 12, "t6_chn0_kept");
    expect_val(K_RD, 4'hA, 8,  "t6_chn2_eof_kept");
    expect_val(K_RD, 4'h6, 8,  "t6_chn2_resp_kept");

    // rst with a burst in flight clears everything, FIFO included
    issue(2'd0, 2'd3, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_val(K_RD,   4'h0, 0, "t6_rst_rd0");
    expect_val(K_RD,   4'hA, 0, "t6_rst_rdA");
    expect_val(K_RD,   4'h6, 0, "t6_rst_rd6");
    bresp();
    expect_val(K_UNF,  4'h0, 1, "t6_rst_fifo_empty");
    expect_val(K_RD,   4'h4, 0, "t6_rst_no_resp");

    tick(); tick();
    if (kind_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", kind_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
